// File: rtl/fft_agu_pkg.sv
// Shared types for the FFT address-generation unit: sequencer state encoding
// and a helper for sizing the drain counter.
package fft_agu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int drain_cw(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/fft_agu_dly.sv
// Fixed-depth shift register with asynchronous active-low clear; aligns the
// write-port bundle with the butterfly datapath output.
module fft_agu_dly #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign q = pipe_reg[DEPTH-1];

endmodule

// File: rtl/fft_agu.sv
// Address generator / sequencer for an in-place radix-2 DIT FFT: issues butterfly
// reads and twiddle indices per stage and a latency-aligned write bundle.
module fft_agu
  import fft_agu_pkg::*;
#(
  parameter int FFT_SIZE     = 4096,
  parameter int ADDR_WIDTH   = 12,
  parameter int BFLY_LATENCY = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          start_bank,
  output logic                          busy,
  output logic                          done,
  output logic                          result_bank,
  output logic [$clog2(ADDR_WIDTH)-1:0] stage,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         rd_addra,
  output logic [ADDR_WIDTH-1:0]         rd_addrb,
  output logic                          rmem_id,
  output logic [ADDR_WIDTH-2:0]         tw_addr,
  output logic [ADDR_WIDTH-1:0]         fft_waddra,
  output logic [ADDR_WIDTH-1:0]         fft_waddrb,
  output logic                          fft_wea,
  output logic                          fft_web,
  output logic                          wmem_id
);

  localparam int SW = $clog2(ADDR_WIDTH);
  localparam int KW = ADDR_WIDTH - 1;
  localparam int CW = drain_cw(BFLY_LATENCY);
  localparam logic [KW-1:0] K_LAST   = KW'(FFT_SIZE / 2 - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(BFLY_LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [SW:0]   SH_ONE   = (SW+1)'(1);
  localparam logic [SW:0]   SH_TOP   = (SW+1)'(ADDR_WIDTH - 1);
  localparam logic          RES_FLIP = 1'(ADDR_WIDTH % 2);

  state_t        state_reg, state_next;
  logic [KW-1:0] k_reg, k_next;
  logic [SW-1:0] s_reg, s_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          bank_reg, bank_next;
  logic          result_reg, result_next;
  logic          wbank_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      k_reg      <= '0;
      s_reg      <= '0;
      cnt_reg    <= '0;
      bank_reg   <= 1'b0;
      result_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      k_reg      <= k_next;
      s_reg      <= s_next;
      cnt_reg    <= cnt_next;
      bank_reg   <= bank_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    s_next      = s_reg;
    cnt_next    = cnt_reg;
    bank_next   = bank_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          bank_next  = start_bank;
          s_next     = '0;
          k_next     = '0;
        end
      end
      RUN: begin
        if (k_reg == K_LAST) begin
          state_next = DRAIN;
          k_next     = '0;
          cnt_next   = CNT_INIT;
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      DRAIN: begin
        cnt_next = cnt_reg - CNT_ONE;
        // Leave only after the last write of this stage has been issued.
        if (cnt_reg == CNT_ONE) begin
          if (s_reg == S_LAST) begin
            state_next  = DONE;
            result_next = bank_reg ^ RES_FLIP;
          end else begin
            state_next = RUN;
            s_next     = s_reg + SW'(1);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [ADDR_WIDTH-1:0] k_ext, span, j, addra;
  logic [KW-1:0]         tw_calc;
  logic [SW:0]           sh_a, sh_tw;

  always_comb begin
    k_ext   = {1'b0, k_reg};
    span    = ADDR_WIDTH'(1) << s_reg;
    j       = k_ext & (span - ADDR_WIDTH'(1));
    sh_a    = {1'b0, s_reg} + SH_ONE;
    sh_tw   = SH_TOP - {1'b0, s_reg};
    addra   = ((k_ext >> s_reg) << sh_a) | j;
    tw_calc = KW'(j << sh_tw);
  end

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign result_bank = result_reg;
  assign stage       = s_reg;
  assign rd_en       = (state_reg == RUN);
  assign rmem_id     = bank_reg ^ s_reg[0];
  // Idle addresses are forced to zero so nothing stale rides the delay line.
  assign rd_addra    = rd_en ? addra : '0;
  assign rd_addrb    = rd_en ? (addra + span) : '0;
  assign tw_addr     = rd_en ? tw_calc : '0;

  logic dly_we, dly_bank;

  fft_agu_dly #(
    .WIDTH (2 * ADDR_WIDTH + 2),
    .DEPTH (BFLY_LATENCY)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({rd_addra, rd_addrb, rd_en, ~rmem_id}),
    .q     ({fft_waddra, fft_waddrb, dly_we, dly_bank})
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wbank_reg <= 1'b0;
    else if (dly_we) wbank_reg <= dly_bank;
  end

  assign fft_wea = dly_we;
  assign fft_web = dly_we;
  assign wmem_id = dly_we ? dly_bank : wbank_reg;

endmodule

// File: doc/fft_agu.md
Name: fft_agu

Overview:
- Address-generation and sequencing unit for the in-place radix-2 DIT FFT core, directly upstream of mem_mux.
- Issues butterfly read addresses, bank select and twiddle index per stage.
- Produces the write-port bundle consumed by mem_mux (fft_waddra/b, fft_wea/b, wmem_id), delayed to align with the butterfly datapath output.
- Ping-pongs the two sample banks stage by stage; data never passes through this block.

Parameters:
- FFT_SIZE, 4096, transform length N; power of two, ≥4.
- ADDR_WIDTH, 12, log2(FFT_SIZE); must equal `ADDR_WIDTH from fft_defs.vh.
- BFLY_LATENCY, 6, cycles from read-address issue to butterfly result valid (includes memory read latency); ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a transform; ignored unless IDLE.
- start_bank  in  1  bank holding input samples; sampled with start.
- busy  out  1  high from cycle after accepted start until done pulse inclusive.
- done  out  1  one-cycle pulse after final write.
- result_bank  out  1  bank holding the finished spectrum; valid when done is high, held until the next start.
- stage  out  ADDR_WIDTH' (clog2(ADDR_WIDTH))  current stage index s.
- rd_en  out  1  read strobe for both ports.
- rd_addra, rd_addrb  out  ADDR_WIDTH each  butterfly operand addresses.
- rmem_id  out  1  bank being read.
- tw_addr  out  ADDR_WIDTH-1  twiddle ROM index.
- fft_waddra, fft_waddrb  out  ADDR_WIDTH each  write addresses to mem_mux.
- fft_wea, fft_web  out  1 each  write enables to mem_mux.
- wmem_id  out  1  bank being written.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM to IDLE; delay line cleared.
- Definitions: L = ADDR_WIDTH; stage s runs 0..L-1; butterfly index k runs 0..N/2-1; span = 2^s; j = k mod span.
- Address arithmetic:
  - rd_addra = ((k>>s)<<(s+1)) | j.
  - rd_addrb = rd_addra + span.
  - tw_addr = j << (L-1-s).
  - All unsigned; no overflow possible within range.
- FSM:
  - IDLE: start=1 → RUN; latch start_bank; s=0; k=0.
  - RUN: rd_en=1 every cycle; k increments. At k=N/2-1 → DRAIN with drain counter = BFLY_LATENCY.
  - DRAIN: rd_en=0; counter decrements each cycle.
    - Counter reaches 0 and s<L-1 → RUN, s+1, k=0.
    - Counter reaches 0 and s=L-1 → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Banking:
  - Stage s reads bank start_bank ^ (s&1).
  - Stage s writes the opposite bank.
  - result_bank = start_bank ^ (L&1).
- Write alignment:
  - {rd_addra, rd_addrb, rd_en, ~rmem_id} passes through a BFLY_LATENCY-deep shift register.
  - Outputs: fft_waddra/b = delayed addresses; fft_wea = fft_web = delayed rd_en; wmem_id = delayed bank.
  - Write for the read issued in cycle t appears in cycle t+BFLY_LATENCY.
- Stage boundary: the first read of stage s+1 occurs in the cycle after the last write of stage s. No read/write overlap on the same bank.
- Timing: the cycle after start is cycle 1. Stage period = N/2 + BFLY_LATENCY cycles. done asserts in cycle L*(N/2+BFLY_LATENCY)+1.
- Boundary rules:
  - start while busy: ignored, no state change.
  - start in the same cycle as done: ignored.
  - wmem_id holds its last value when write enables are low.
  - Reset mid-transform: immediate abort; write enables drop asynchronously; no further writes.

Decomposition:
- fft_defs.vh (shared) holds ADDR_WIDTH and the FSM state encoding (IDLE, RUN, DRAIN, DONE).
- One sub-module: fft_agu_dly, a parameterised-width, parameterised-depth shift register with async active-low clear, used for write alignment.

Test Plan:
- FFT_SIZE=8, BFLY_LATENCY=4, start_bank=0 → stage 0 reads (0,1),(2,3),(4,5),(6,7), tw 0 throughout, rmem_id=0; writes of the same pairs in cycles 5–8 with wmem_id=1.
- Same config, stage 1 → reads (0,2) tw0, (1,3) tw2, (4,6) tw0, (5,7) tw2 in cycles 9–12, rmem_id=1.
- Same config, stage 2 → reads (0,4) tw0, (1,5) tw1, (2,6) tw2, (3,7) tw3 in cycles 17–20; done in cycle 25; result_bank=1.
- FFT_SIZE=4096, BFLY_LATENCY=6, start_bank=1 → done at cycle 12*(2048+6)+1 = 24649; result_bank=1; no cycle with both rd_en and fft_wea on the same bank.
- start pulsed again at cycle 10 of a running transform → ignored; address sequence and done cycle unchanged.
- rst_n low in cycle 7 of FFT_SIZE=8 run → all outputs 0 same cycle; after release, new start gives the full sequence from stage 0.
